// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared constants and state encoding for the PWM ramp controller
package pwm_ctrl_pkg;

    localparam int DUTY_W      = 9;
    localparam int PRESC_W     = 8;
    localparam int STEP_W      = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int DUTY_MAX    = 256;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RAMP = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] t);
        return (t > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : t;
    endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// rtl/pwm_frame_timer.sv - counts one PWM frame (256 * (prescale + 1) clocks) and ticks on its last clock
module pwm_frame_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               frame_tick
);

    logic [FRAME_CNT_W-1:0] cnt;
    logic [FRAME_CNT_W-1:0] term;

    // 256 * (P + 1) - 1 is simply P in the high byte with 0xFF below it
    assign term       = FRAME_CNT_W'({prescale, 8'hFF});
    assign frame_tick = enable && (cnt == term);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= frame_tick ? '0 : cnt + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start / fade sequencer stepping PWM duty once per frame toward a target
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W  = 9,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DUTY_W-1:0]  cmd_target,
    input  logic [STEP_W-1:0]  cmd_step,
    input  logic [PRESC_W-1:0] cmd_prescale,
    input  logic               abort,
    output logic [PRESC_W-1:0] Final_Value,
    output logic [DUTY_W-1:0]  duty,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_nxt;
    logic [DUTY_W-1:0]  tgt_q;
    logic [STEP_W-1:0]  step_q;
    logic [PRESC_W-1:0] presc_q;
    logic               frame_tick;
    logic               accept;
    logic signed [DUTY_W:0] cur_s;
    logic signed [DUTY_W:0] stp_s;
    logic signed [DUTY_W:0] tgt_s;
    logic signed [DUTY_W:0] sum_s;
    logic [DUTY_W-1:0]  next_duty;

    assign accept = (state == ST_IDLE) && cmd_ready && cmd_valid;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

    pwm_frame_timer #(
        .PRESC_W (PRESC_W)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == ST_LOAD),
        .enable     (state == ST_RAMP),
        .prescale   (Final_Value),
        .frame_tick (frame_tick)
    );

    // One step toward target; the signed sum may leave 0..256, so saturate at target
    always_comb begin
        cur_s = signed'({1'b0, duty});
        tgt_s = signed'({1'b0, tgt_q});
        stp_s = signed'({{(DUTY_W + 1 - STEP_W){1'b0}}, step_q});
        if (tgt_q > duty) begin
            sum_s     = cur_s + stp_s;
            next_duty = (sum_s >= tgt_s) ? tgt_q : sum_s[DUTY_W-1:0];
        end else begin
            sum_s     = cur_s - stp_s;
            next_duty = (sum_s <= tgt_s) ? tgt_q : sum_s[DUTY_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (abort)                                  state_nxt = ST_IDLE;
                else if (step_q == '0 || duty == tgt_q)     state_nxt = ST_DONE;
                else                                        state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (abort)                                  state_nxt = ST_IDLE;
                else if (frame_tick && next_duty == tgt_q)  state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            duty        <= '0;
            Final_Value <= '0;
            tgt_q       <= '0;
            step_q      <= '0;
            presc_q     <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            if (accept) begin
                tgt_q   <= clamp_duty(cmd_target);
                step_q  <= cmd_step;
                presc_q <= cmd_prescale;
            end
            // abort leaves duty and Final_Value exactly where they are
            if (state == ST_LOAD && !abort) begin
                Final_Value <= presc_q;
                if (step_q == '0) duty <= tgt_q;
            end
            if (state == ST_RAMP && !abort && frame_tick) begin
                duty <= next_duty;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl with a frame-level reference model
module tb_pwm_ramp_ctrl;

    typedef struct {
        int cyc;
        int duty;
        int fv;
        bit done;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_prescale;
    logic       abort;
    logic [7:0] Final_Value;
    logic [8:0] duty;
    logic       busy;
    logic       done;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  m_duty = 0;
    int  m_fv = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];
    ev_t pend[$];

    pwm_ramp_ctrl #(
        .DUTY_W  (9),
        .PRESC_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_prescale (cmd_prescale),
        .abort        (abort),
        .Final_Value  (Final_Value),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input int d, input int f, input bit dn);
        ev_t r;
        r.cyc  = c;
        r.duty = d;
        r.fv   = f;
        r.done = dn;
        return r;
    endfunction

    // Reference: a command accepted at edge k loads at k+1, then steps every 256*(P+1) edges
    task automatic build(input int k, input int d, input int fv, input int t, input int s, input int p);
        int n;
        int e;
        n = 256 * (p + 1);
        pend.delete();
        if (s == 0) begin
            pend.push_back(mk(k + 1, t, p, 1'b1));
        end else if (d == t) begin
            pend.push_back(mk(k + 1, d, p, 1'b1));
        end else begin
            if (p != fv) pend.push_back(mk(k + 1, d, p, 1'b0));
            e = k + 1;
            while (d != t) begin
                e += n;
                if (d < t) d = (d + s > t) ? t : d + s;
                else       d = (d - s < t) ? t : d - s;
                pend.push_back(mk(e, d, p, d == t));
            end
        end
    endtask

    task automatic issue(input int tgt, input int s, input int p,
                         input int abort_off, input int rst_off, input int junk_off);
        int k, t, last, stop, budget, a_edge, r_edge, dv, fvv;
        budget = 0;
        while (!cmd_ready && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", cmd_ready, 1);
            return;
        end
        cmd_valid    = 1'b1;
        cmd_target   = 9'(tgt);
        cmd_step     = 8'(s);
        cmd_prescale = 8'(p);
        k = cyc + 1;
        t = (tgt > 256) ? 256 : tgt;
        build(k, m_duty, m_fv, t, s, p);
        last   = pend[$].cyc;
        a_edge = (abort_off > 0 && k + abort_off <= last) ? k + abort_off : 0;
        r_edge = (rst_off > 0 && k + rst_off <= last) ? k + rst_off : 0;
        stop   = last;
        if (a_edge != 0) begin
            while (pend.size() > 0 && pend[$].cyc >= a_edge) void'(pend.pop_back());
            stop = a_edge;
        end
        if (r_edge != 0) begin
            while (pend.size() > 0 && pend[$].cyc >= r_edge) void'(pend.pop_back());
            dv  = (pend.size() > 0) ? pend[$].duty : m_duty;
            fvv = (pend.size() > 0) ? pend[$].fv : m_fv;
            if (dv != 0 || fvv != 0) pend.push_back(mk(r_edge, 0, 0, 1'b0));
            else begin
                m_duty = 0;
                m_fv   = 0;
            end
            stop = r_edge;
        end
        if (pend.size() > 0) begin
            m_duty = pend[$].duty;
            m_fv   = pend[$].fv;
        end
        foreach (pend[i]) exp_q.push_back(pend[i]);
        while (cyc < stop + 2) begin
            @(negedge clk);
            if (a_edge != 0 && cyc == a_edge) chk("abort_busy", busy, 0);
            if (r_edge != 0 && cyc == r_edge) begin
                chk("reset_busy", busy, 0);
                chk("reset_ready", cmd_ready, 0);
            end
            if (r_edge != 0 && cyc == r_edge + 1) chk("ready_after_release", cmd_ready, 1);
            cmd_valid = (junk_off > 0 && cyc + 1 == k + junk_off);
            if (cmd_valid) begin
                cmd_target = 9'd5;
                cmd_step   = 8'd1;
            end
            abort = (a_edge != 0 && cyc + 1 == a_edge);
            reset = !(r_edge != 0 && cyc + 1 == r_edge);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        reset     = 1'b1;
    endtask

    // Monitor: every change of duty/Final_Value, or a done pulse, must match the next expected event
    int pd = 0;
    int pf = 0;
    bit chk_after_done = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (!mon_en) begin
            pd = int'(duty);
            pf = int'(Final_Value);
        end else begin
            if (chk_after_done) begin
                chk("ready_after_done", cmd_ready, 1);
                chk("busy_after_done", busy, 0);
                chk_after_done = 1'b0;
            end
            if (int'(duty) != pd || int'(Final_Value) != pf || done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event @cyc %0d: duty %0d fv %0d done %0d, none expected",
                             cyc, duty, Final_Value, done);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_duty", int'(duty), e.duty);
                    chk("ev_fv", int'(Final_Value), e.fv);
                    chk("ev_done", int'(done), int'(e.done));
                    if (done) begin
                        chk("busy_in_done", busy, 1);
                        chk("ready_in_done", cmd_ready, 0);
                        chk_after_done = 1'b1;
                    end
                end
            end
            pd = int'(duty);
            pf = int'(Final_Value);
        end
    end

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_target   = '0;
        cmd_step     = '0;
        cmd_prescale = '0;
        abort        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_fv", int'(Final_Value), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", cmd_ready, 1);
        mon_en = 1'b1;

        issue(64, 16, 3, 0, 0, 0);
        issue(200, 0, 0, 0, 0, 0);
        issue(50, 64, 0, 0, 0, 0);
        issue(300, 0, 2, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0);
        issue(200, 10, 0, 1 + 3 * 256, 0, 0);
        issue(100, 40, 1, 0, 0, 700);
        issue(150, 20, 1, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0);
        issue(200, 16, 0, 0, 1 + 3 * 256 + 10, 0);

        for (int i = 0; i < 15; i++) begin
            int tg, s, p, ab;
            tg = $urandom_range(0, 300);
            s  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(40, 255);
            p  = $urandom_range(0, 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1200) : 0;
            issue(tg, s, p, ab, 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start / fade sequencer that drives the configuration inputs (`Final_Value`, `duty`) of the PWM generator. It accepts one ramp command at a time and moves `duty` from its present value toward a target in fixed steps. It applies one step per PWM frame, then pulses `done`. It sits directly in front of the PWM instance and is the only writer of its `Final_Value` and `duty` inputs.

## Interface
Parameters:
- `DUTY_W`, 9: duty width; full scale 256 = 100 %.
- `PRESC_W`, 8: prescaler (`Final_Value`) width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset; one clock domain (`clk`) only.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on the edge where `cmd_valid && cmd_ready`.
- `cmd_target`  in  9  target duty; values > 256 are clamped to 256.
- `cmd_step`  in  8  duty increment per frame; 0 = jump immediately.
- `cmd_prescale`  in  8  `Final_Value` to apply for this ramp.
- `abort`  in  1  stop the ramp at the current duty.
- `Final_Value`  out  8  to PWM; registered.
- `duty`  out  9  to PWM; registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when `duty` reaches target.

## Operation
- States: IDLE, LOAD, RAMP, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept, latch target (clamped), step and prescale, then go to LOAD.
- **LOAD** (1 cycle)
  - `Final_Value` <= latched prescale.
  - Frame counter <= 0.
  - If `cmd_step` = 0: `duty` <= target and go to DONE.
  - Else if `duty` = target: go to DONE.
  - Else: go to RAMP.
- **RAMP**
  - The frame counter (16 bit) counts 0 .. 256·(P+1)−1, where P = `Final_Value`. This equals one PWM frame.
  - At the terminal count:
    - `duty` <= `duty` ± step, saturating at target (never overshoots; never < 0 or > 256).
    - Frame counter <= 0.
  - If the new `duty` equals target, go to DONE.
- **DONE** (1 cycle)
  - `done` = 1, then go to IDLE.
- **abort**
  - Abort in LOAD or RAMP: go to IDLE next edge, `duty` and `Final_Value` hold their present values, no `done` pulse.
  - Abort and terminal count on the same edge: abort wins, no duty update.
  - Abort in IDLE or DONE: ignored.
- `cmd_valid` outside IDLE is ignored; the command is not queued.
- Arithmetic: compute in 10 bits signed, compare against target, then select target or sum.

## Timing
- Reset (`reset` = 0 at an edge): state IDLE, `duty` = 0, `Final_Value` = 0, `cmd_ready` = 0, `busy` = 0, `done` = 0, frame counter = 0.
  - `cmd_ready` rises on the first edge with `reset` = 1.
  - Reset mid-ramp discards the command immediately.
- Accept at edge k:
  - LOAD occupies k..k+1.
  - `Final_Value` is updated at edge k+1.
- First duty step at edge k+1+256·(P+1); subsequent steps every 256·(P+1) clocks.
- `done` is high for the cycle following the edge that wrote the final `duty`.
- Earliest next accept: the cycle after `done`.
- Zero-step and already-at-target commands: `done` at edge k+2; `busy` high for 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs except none (`cmd_ready` decodes state only).

## Structure
- Package `pwm_ctrl_pkg`: state enum (IDLE/LOAD/RAMP/DONE), `DUTY_MAX` = 256, `DUTY_W`, `PRESC_W`, `FRAME_CNT_W` = 16.
- Sub-module `pwm_frame_timer`:
  - Inputs: `clk`, `reset`, `clear`, `enable`, `prescale`.
  - Output: one-cycle `frame_tick` at count 256·(prescale+1)−1.
  - The PWM testbench reuses it for frame-boundary checks.
- Top: FSM + duty update datapath.

## Test plan
1. Reset, then cmd (target 64, step 16, prescale 3) → `Final_Value` = 3; `duty` 16/32/48/64 at 1024-clock intervals; `done` once; `busy` low afterwards.
2. From duty 200: cmd (target 50, step 64) → `duty` 136, 72, then 50 (saturated, no undershoot); `done` after third step.
3. Cmd target 300, step 0 → `duty` = 256 two cycles after accept; `done` pulse; `cmd_ready` back high next cycle.
4. Ramp 0→200, step 10, prescale 0: assert `abort` on the same edge as the 3rd frame tick → `duty` stays 20; no `done`; IDLE; `Final_Value` = 0 retained.
5. During a ramp, pulse `cmd_valid` with target 5 → ignored; the original ramp completes unchanged.
6. Drive `reset` low mid-ramp (`duty` = 48) → next edge `duty` = 0, `Final_Value` = 0, `busy` = 0; `cmd_ready` = 1 one edge after release.
